// File: rtl/avr_io_irqctl_if.sv
// ---------------------------------------------------------------------------
// avr_io_irqctl_if
// IO-space write/read strobe bundle used between the core's IO decoder and
// the interrupt controller register window.
//   io_re  : read strobe, already qualified by the window's address select
//   io_we  : write strobe, already qualified by the window's address select
//   io_a   : register index within the 4-register window
//   io_do  : write data from the core
// The read-data return path (io_di) is a shared tri-state bus and stays a
// plain port on the peripheral so each peripheral drives it independently.
// ---------------------------------------------------------------------------
interface avr_io_irqctl_if;
    logic       io_re;
    logic       io_we;
    logic [1:0] io_a;
    logic [7:0] io_do;

    modport master (output io_re, output io_we, output io_a, output io_do);
    modport slave  (input  io_re, input  io_we, input  io_a, input  io_do);
endinterface

// File: rtl/avr_io_irqctl.sv
// ---------------------------------------------------------------------------
// avr_io_irqctl
// IO-mapped interrupt controller for the AVR core. Latches up to 8 request
// lines with per-channel edge/level mode, enable mask, software trigger and
// hardware acknowledge, and presents a registered iflag/ivect pair.
//
// Parameters
//   channels   : number of request inputs (1..8)
//   intr_width : width of ivect; 2**intr_width >= channels, intr_width <= 7
// Ports
//   clk     : system clock, rising edge
//   rst     : asynchronous active-low reset
//   bus     : IO strobes/address/write data (slave side)
//   io_di   : read data, driven only while bus.io_re = 1, else high-Z
//   irq_i   : request lines, synchronous to clk
//   irq_ack : one-cycle pulse when the core takes the vector on ivect
//   iflag   : registered, an enabled interrupt is pending
//   ivect   : registered index of the lowest-numbered enabled pending channel
//
// Register window (io_a)
//   0 IMSK  R/W  enable mask
//   1 IPND  R    pending; write-1-to-clear on edge channels
//   2 IMODE R/W  1 = rising-edge channel, 0 = level channel
//   3 ISTAT R    {iflag, zeros, ivect}; write = software trigger (edge only)
// ---------------------------------------------------------------------------
module avr_io_irqctl #(
    parameter int channels   = 4,
    parameter int intr_width = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    avr_io_irqctl_if.slave        bus,
    output wire  [7:0]            io_di,
    input  logic [channels-1:0]   irq_i,
    input  logic                  irq_ack,
    output logic                  iflag,
    output logic [intr_width-1:0] ivect
);

    localparam logic [1:0] A_IMSK  = 2'd0;
    localparam logic [1:0] A_IPND  = 2'd1;
    localparam logic [1:0] A_IMODE = 2'd2;
    localparam logic [1:0] A_ISTAT = 2'd3;

    logic [channels-1:0] imsk;
    logic [channels-1:0] ipnd;
    logic [channels-1:0] imode;
    logic [channels-1:0] prev;

    logic [channels-1:0] w1c;
    logic [channels-1:0] swt;
    logic [channels-1:0] ack_vec;
    logic [channels-1:0] edge_set;
    logic [channels-1:0] pnd_edge;
    logic [channels-1:0] pnd_next;
    logic [channels-1:0] active;
    logic [7:0]          rdata;

    // Write data bits at or above `channels` are deliberately dropped.
    logic unused_io_do;
    assign unused_io_do = ^bus.io_do;

    // Lowest index wins: scan downward so the last hit is the smallest index.
    function automatic logic [intr_width-1:0] prio_index(input logic [channels-1:0] v);
        prio_index = '0;
        for (int i = channels - 1; i >= 0; i--) begin
            if (v[i]) prio_index = intr_width'(i);
        end
    endfunction

    always_comb begin
        w1c     = '0;
        swt     = '0;
        ack_vec = '0;
        if (bus.io_we && bus.io_a == A_IPND)  w1c = bus.io_do[channels-1:0];
        if (bus.io_we && bus.io_a == A_ISTAT) swt = bus.io_do[channels-1:0];
        for (int i = 0; i < channels; i++) begin
            ack_vec[i] = irq_ack && (ivect == intr_width'(i));
        end
        edge_set = irq_i & ~prev;
        // Clears are applied first so any set on the same edge overrides them.
        pnd_edge = (ipnd & ~(w1c | ack_vec)) | edge_set | swt;
        // Mode is taken from the current register, so an IMODE write only
        // changes pending behaviour from the following edge.
        pnd_next = (imode & pnd_edge) | (~imode & irq_i);
        active   = ipnd & imsk;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            imsk  <= '0;
            ipnd  <= '0;
            imode <= '0;
            prev  <= '0;
            iflag <= 1'b0;
            ivect <= '0;
        end else begin
            prev  <= irq_i;
            ipnd  <= pnd_next;
            if (bus.io_we && bus.io_a == A_IMSK)  imsk  <= bus.io_do[channels-1:0];
            if (bus.io_we && bus.io_a == A_IMODE) imode <= bus.io_do[channels-1:0];
            // Output stage follows the registered pending/mask one edge later.
            iflag <= |active;
            ivect <= prio_index(active);
        end
    end

    always_comb begin
        rdata = '0;
        case (bus.io_a)
            A_IMSK:  rdata[channels-1:0] = imsk;
            A_IPND:  rdata[channels-1:0] = ipnd;
            A_IMODE: rdata[channels-1:0] = imode;
            default: begin
                rdata[7]              = iflag;
                rdata[intr_width-1:0] = ivect;
            end
        endcase
    end

    assign io_di = bus.io_re ? rdata : 8'hzz;

endmodule
